// File: rtl/paddle_tracker.sv
// Paddle position, score and lives tracker for a sweeping paddle that walks
// between two column limits, drops a few rows at each edge and respawns when lost.
module paddle_tracker #(
    parameter int COL_MIN   = 40,
    parameter int COL_MAX   = 583,
    parameter int ROW_START = 100,
    parameter int DROP_ROWS = 16,
    parameter int LIVES     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame,
    input  logic        frame2,
    input  logic        start,
    input  logic        padcolce,
    input  logic        padrowce,
    input  logic        paddlescore,
    input  logic        paddlegone,
    output logic [15:0] paddlecol,
    output logic [15:0] paddlerow,
    output logic [7:0]  score,
    output logic [1:0]  lives,
    output logic        game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_DROP,
        S_NUDGE,
        S_GONE,
        S_OVER
    } state_t;

    localparam logic [15:0] COL_MIN_L   = 16'(COL_MIN);
    localparam logic [15:0] COL_MAX_L   = 16'(COL_MAX);
    localparam logic [15:0] COL_START_L = 16'(COL_MIN + 1);
    localparam logic [15:0] ROW_START_L = 16'(ROW_START);
    localparam logic [15:0] DROP_ROWS_L = 16'(DROP_ROWS);
    localparam logic [1:0]  LIVES_L     = 2'(LIVES);

    state_t      r_state;
    logic [15:0] r_col;
    logic [15:0] r_row;
    logic        r_dir;
    logic [15:0] r_dropCnt;
    logic        r_scored;
    logic [7:0]  r_score;
    logic [1:0]  r_lives;
    logic        r_gameOver;

    logic [15:0] w_colInc;
    logic [15:0] w_colDec;
    logic [1:0]  w_livesDec;
    logic        w_active;
    logic        w_scoredBase;
    logic        w_scoredNext;
    logic [7:0]  w_scoreNext;

    // frame2 only paces the renderer's row enable, which we already see as padrowce
    logic w_unused;
    assign w_unused = frame2;

    always_comb begin
        w_colInc     = (r_col < COL_MAX_L) ? r_col + 16'd1 : r_col;
        w_colDec     = (r_col > COL_MIN_L) ? r_col - 16'd1 : r_col;
        w_livesDec   = (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
        w_active     = (r_state == S_MOVE) || (r_state == S_DROP) ||
                       (r_state == S_NUDGE) || (r_state == S_GONE);
        w_scoredBase = frame ? 1'b0 : r_scored;
        w_scoredNext = w_scoredBase;
        w_scoreNext  = r_score;
        if (paddlescore && !w_scoredBase) begin
            w_scoredNext = 1'b1;
            w_scoreNext  = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
        end
    end

    // A start in IDLE/OVER is placed after the scoring update so its clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_col      <= COL_MIN_L;
            r_row      <= ROW_START_L;
            r_dir      <= 1'b1;
            r_dropCnt  <= 16'd0;
            r_scored   <= 1'b0;
            r_score    <= 8'd0;
            r_lives    <= LIVES_L;
            r_gameOver <= 1'b0;
        end else begin
            if (w_active) begin
                r_scored <= w_scoredNext;
                r_score  <= w_scoreNext;
            end
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        r_state    <= S_MOVE;
                        r_col      <= COL_START_L;
                        r_row      <= ROW_START_L;
                        r_dir      <= 1'b1;
                        r_dropCnt  <= 16'd0;
                        r_scored   <= 1'b0;
                        r_score    <= 8'd0;
                        r_lives    <= LIVES_L;
                        r_gameOver <= 1'b0;
                    end
                end
                S_MOVE: begin
                    if (paddlegone) begin
                        r_state <= S_GONE;
                        r_lives <= w_livesDec;
                    end else if ((r_col == COL_MIN_L) || (r_col == COL_MAX_L)) begin
                        r_state   <= S_DROP;
                        r_dropCnt <= 16'd0;
                    end else if (padcolce) begin
                        r_col <= r_dir ? w_colInc : w_colDec;
                    end
                end
                S_DROP: begin
                    if (paddlegone) begin
                        r_state <= S_GONE;
                        r_lives <= w_livesDec;
                    end else if (r_dropCnt >= DROP_ROWS_L) begin
                        r_state <= S_NUDGE;
                    end else if (padrowce) begin
                        r_row     <= r_row + 16'd1;
                        r_dropCnt <= r_dropCnt + 16'd1;
                    end
                end
                S_NUDGE: begin
                    if (paddlegone) begin
                        r_state <= S_GONE;
                        r_lives <= w_livesDec;
                    end else if (frame) begin
                        r_col   <= r_dir ? w_colDec : w_colInc;
                        r_dir   <= ~r_dir;
                        r_state <= S_MOVE;
                    end
                end
                S_GONE: begin
                    if (frame) begin
                        r_col <= COL_START_L;
                        r_row <= ROW_START_L;
                        r_dir <= 1'b1;
                        if (r_lives != 2'd0) begin
                            r_state <= S_MOVE;
                        end else begin
                            r_state    <= S_OVER;
                            r_gameOver <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign paddlecol = r_col;
    assign paddlerow = r_row;
    assign score     = r_score;
    assign lives     = r_lives;
    assign game_over = r_gameOver;

endmodule
